// File: rtl/serial_add_seq_if.sv
// Operand request, full-adder cell link and result bundle
// for the bit-serial adder sequencer.
interface serial_add_seq_if #(
    parameter int N = 8
);
    logic         START;
    logic [N-1:0] A_IN;
    logic [N-1:0] B_IN;
    logic         CIN;
    logic         FA_A;
    logic         FA_B;
    logic         FA_C;
    logic         FA_S;
    logic         FA_CY;
    logic [N-1:0] SUM;
    logic         COUT;
    logic         BUSY;
    logic         DONE;

    // master is the environment: requester plus the full-adder cell
    modport master (
        output START, A_IN, B_IN, CIN, FA_S, FA_CY,
        input  FA_A, FA_B, FA_C, SUM, COUT, BUSY, DONE
    );

    modport slave (
        input  START, A_IN, B_IN, CIN, FA_S, FA_CY,
        output FA_A, FA_B, FA_C, SUM, COUT, BUSY, DONE
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial N-bit adder sequencer driving an external
// combinational full-adder cell, one bit per clock.
module serial_add_seq #(
    parameter int N = 8
) (
    input logic            CLK,
    input logic            RST,
    serial_add_seq_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  ps_q;
    logic [N-1:0]  ps_next;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  sum_q;
    logic          cout_q;
    logic          done_q;
    logic          busy;
    logic          last;

    assign busy = (state_q == SHIFT);
    assign last = busy && (cnt_q == CW'(N - 1));

    // Partial sum fills from the MSB; N=1 has no upper slice to keep
    if (N == 1) begin : g_one
        assign ps_next = bus.FA_S;
    end else begin : g_multi
        assign ps_next = {bus.FA_S, ps_q[N-1:1]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = SHIFT;
            SHIFT:   if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_sr    <= '0;
            b_sr    <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy) begin
                if (bus.START) begin
                    a_sr    <= bus.A_IN;
                    b_sr    <= bus.B_IN;
                    carry_q <= bus.CIN;
                    ps_q    <= '0;
                    cnt_q   <= '0;
                end
            end else begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                ps_q    <= ps_next;
                carry_q <= bus.FA_CY;
                cnt_q   <= cnt_q + CW'(1);
                if (last) begin
                    sum_q  <= ps_next;
                    cout_q <= bus.FA_CY;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.FA_A = busy & a_sr[0];
    assign bus.FA_B = busy & b_sr[0];
    assign bus.FA_C = busy & carry_q;
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.BUSY = busy;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: behavioural full-adder cell plus
// an arithmetic reference for sums, carries and timing.
module tb_serial_add_seq;
    localparam int N = 8;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_add_seq_if #(.N(N)) bus ();

    serial_add_seq #(.N(N)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // The gate-level full-adder cell
    assign bus.FA_S  = bus.FA_A ^ bus.FA_B ^ bus.FA_C;
    assign bus.FA_CY = (bus.FA_A & bus.FA_B) | (bus.FA_C & (bus.FA_A ^ bus.FA_B));

    function automatic logic [N:0] ref_add(logic [N-1:0] a, logic [N-1:0] b, logic c);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    endfunction

    // Carry into bit i of a+b+c
    function automatic logic ref_carry(logic [N-1:0] a, logic [N-1:0] b, logic c, int i);
        int m;
        int s;
        m = (1 << i) - 1;
        s = (int'(a) & m) + (int'(b) & m) + int'(c);
        return logic'((s >> i) & 1);
    endfunction

    // Caller is #1 after an edge with the DUT idle; returns in the DONE cycle
    task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           output int lat, output int busy_n);
        bus.A_IN = a; bus.B_IN = b; bus.CIN = c; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        lat = 0; busy_n = 0;
        for (int i = 0; i < 4 * N; i++) begin
            if (bus.BUSY) busy_n++;
            if (bus.DONE) break;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.START = 1'b0;
        bus.A_IN = '0; bus.B_IN = '0; bus.CIN = 1'b0;
        #12;
        n_cmp++;
        if ({bus.SUM, bus.COUT, bus.BUSY, bus.DONE, bus.FA_A, bus.FA_B, bus.FA_C} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got sum=%h cout=%b busy=%b done=%b fa=%b%b%b want all 0",
                     bus.SUM, bus.COUT, bus.BUSY, bus.DONE, bus.FA_A, bus.FA_B, bus.FA_C);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.BUSY, bus.DONE);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        logic [N:0] exp;
        exp = ref_add(8'h5A, 8'h3C, 1'b0);
        run_add(8'h5A, 8'h3C, 1'b0, lat, bn);
        n_cmp++;
        if (lat !== N) begin
            n_err++; $display("FAIL basic_latency got %0d want %0d", lat, N);
        end
        n_cmp++;
        if (bn !== N) begin
            n_err++; $display("FAIL basic_busy_cycles got %0d want %0d", bn, N);
        end
        n_cmp++;
        if ({bus.COUT, bus.SUM} !== exp) begin
            n_err++; $display("FAIL basic_sum got %b_%h want %h", bus.COUT, bus.SUM, exp);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.DONE !== 1'b0 || {bus.COUT, bus.SUM} !== exp) begin
            n_err++;
            $display("FAIL basic_done_pulse got done=%b sum=%h want done=0 sum=%h",
                     bus.DONE, bus.SUM, exp[N-1:0]);
        end
    endtask

    task automatic test_overflow();
        int lat, bn;
        logic [N-1:0] av [2];
        logic [N-1:0] bv [2];
        logic         cv [2];
        av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
        av[1] = 8'hFF; bv[1] = 8'hFF; cv[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_add(av[i], bv[i], cv[i], lat, bn);
            n_cmp++;
            if ({bus.COUT, bus.SUM} !== ref_add(av[i], bv[i], cv[i])) begin
                n_err++;
                $display("FAIL overflow_%0d got %b_%h want %h", i, bus.COUT, bus.SUM,
                         ref_add(av[i], bv[i], cv[i]));
            end
        end
    endtask

    task automatic test_trace(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [2:0] exp3;
        bus.A_IN = a; bus.B_IN = b; bus.CIN = c; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        for (int s = 0; s < N; s++) begin
            exp3 = {a[s], b[s], ref_carry(a, b, c, s)};
            n_cmp++;
            if ({bus.FA_A, bus.FA_B, bus.FA_C} !== exp3) begin
                n_err++;
                $display("FAIL trace_shift%0d got %b%b%b want %b", s,
                         bus.FA_A, bus.FA_B, bus.FA_C, exp3);
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (bus.DONE !== 1'b1 || {bus.COUT, bus.SUM} !== ref_add(a, b, c)) begin
            n_err++;
            $display("FAIL trace_result got done=%b %b_%h want done=1 %h",
                     bus.DONE, bus.COUT, bus.SUM, ref_add(a, b, c));
        end
        n_cmp++;
        if ({bus.FA_A, bus.FA_B, bus.FA_C, bus.BUSY} !== 4'b0) begin
            n_err++;
            $display("FAIL trace_idle_fa got %b%b%b busy=%b want 0000",
                     bus.FA_A, bus.FA_B, bus.FA_C, bus.BUSY);
        end
    endtask

    task automatic test_start_busy();
        int dones = 0;
        logic [N:0] got = '0;
        bus.A_IN = 8'h10; bus.B_IN = 8'h20; bus.CIN = 1'b0; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        for (int cyc = 0; cyc < 3 * N; cyc++) begin
            if (cyc == 3) begin
                bus.A_IN = 8'hAA; bus.B_IN = 8'h55; bus.START = 1'b1;
            end else begin
                bus.START = 1'b0;
            end
            if (bus.DONE) begin
                dones++;
                got = {bus.COUT, bus.SUM};
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++; $display("FAIL start_busy_dones got %0d want 1", dones);
        end
        n_cmp++;
        if (got !== ref_add(8'h10, 8'h20, 1'b0)) begin
            n_err++;
            $display("FAIL start_busy_sum got %h want %h", got, ref_add(8'h10, 8'h20, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a1, b1, a2, b2;
        logic c1, c2;
        int lat;
        a1 = N'($urandom); b1 = N'($urandom); c1 = 1'($urandom);
        a2 = N'($urandom); b2 = N'($urandom); c2 = 1'($urandom);
        bus.A_IN = a1; bus.B_IN = b1; bus.CIN = c1; bus.START = 1'b1;
        @(posedge CLK); #1;
        // START stays high; the new operands must wait for the DONE cycle
        bus.A_IN = a2; bus.B_IN = b2; bus.CIN = c2;
        lat = 0;
        while (!bus.DONE && lat < 4 * N) begin
            @(posedge CLK); #1; lat++;
        end
        n_cmp++;
        if (lat !== N || {bus.COUT, bus.SUM} !== ref_add(a1, b1, c1)) begin
            n_err++;
            $display("FAIL b2b_first got lat=%0d %b_%h want lat=%0d %h",
                     lat, bus.COUT, bus.SUM, N, ref_add(a1, b1, c1));
        end
        @(posedge CLK); #1;
        bus.START = 1'b0;
        n_cmp++;
        if (bus.BUSY !== 1'b1) begin
            n_err++; $display("FAIL b2b_no_bubble got busy=%b want 1", bus.BUSY);
        end
        lat = 0;
        while (!bus.DONE && lat < 4 * N) begin
            @(posedge CLK); #1; lat++;
        end
        n_cmp++;
        if (lat !== N || {bus.COUT, bus.SUM} !== ref_add(a2, b2, c2)) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d %b_%h want lat=%0d %h",
                     lat, bus.COUT, bus.SUM, N, ref_add(a2, b2, c2));
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat, bn;
        bus.A_IN = 8'hC3; bus.B_IN = 8'h7E; bus.CIN = 1'b1; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({bus.SUM, bus.COUT, bus.BUSY, bus.DONE, bus.FA_A, bus.FA_B, bus.FA_C} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs got sum=%h cout=%b busy=%b done=%b fa=%b%b%b want all 0",
                     bus.SUM, bus.COUT, bus.BUSY, bus.DONE, bus.FA_A, bus.FA_B, bus.FA_C);
        end
        @(posedge CLK); #3 RST = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge CLK); #1;
            if (bus.DONE) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++; $display("FAIL reset_mid_no_done got %0d pulses want 0", dones);
        end
        run_add(8'h01, 8'h01, 1'b0, lat, bn);
        n_cmp++;
        if ({bus.COUT, bus.SUM} !== ref_add(8'h01, 8'h01, 1'b0) || lat !== N) begin
            n_err++;
            $display("FAIL reset_mid_fresh got lat=%0d %b_%h want lat=%0d %h",
                     lat, bus.COUT, bus.SUM, N, ref_add(8'h01, 8'h01, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        logic c;
        int lat, bn;
        for (int i = 0; i < 20; i++) begin
            a = N'($urandom); b = N'($urandom); c = 1'($urandom);
            run_add(a, b, c, lat, bn);
            n_cmp++;
            if ({bus.COUT, bus.SUM} !== ref_add(a, b, c) || lat !== N || bn !== N) begin
                n_err++;
                $display("FAIL random_%0d %h+%h+%b got lat=%0d busy=%0d %b_%h want %h",
                         i, a, b, c, lat, bn, bus.COUT, bus.SUM, ref_add(a, b, c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_trace(8'h03, 8'h01, 1'b0);
        test_trace(N'($urandom), N'($urandom), 1'($urandom));
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
